// File: rtl/vbuf_pkg.sv
// Shared types and constants for the video frame-buffer scheduler.
package vbuf_pkg;

  // Buffer indices are carried on 4-bit ports regardless of BUF_NUM.
  localparam int unsigned BUF_IDX_W = 4;

  // Legal range for the number of buffers in rotation.
  localparam int unsigned BUF_NUM_MIN = 3;
  localparam int unsigned BUF_NUM_MAX = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } sched_state_e;

endpackage

// File: rtl/vbuf_next_sel.sv
// Combinational search for the next buffer the writer may use: the first index
// after cur (mod BUF_NUM) that is neither being read nor holding an unread frame.
module vbuf_next_sel
  import vbuf_pkg::*;
#(
  parameter int unsigned BUF_NUM = 3
) (
  input  logic [BUF_IDX_W-1:0] cur_i,
  input  logic [BUF_IDX_W-1:0] rbuf_i,
  input  logic [BUF_IDX_W-1:0] latest_i,
  input  logic                 ready_i,
  output logic [BUF_IDX_W-1:0] nxt_o
);

  // One extra bit so cur + offset (at most 2*BUF_NUM-1) never overflows.
  localparam int unsigned SumW = BUF_IDX_W + 1;

  logic            found;
  logic [SumW-1:0] sum;
  logic [BUF_IDX_W-1:0] cand;

  // Scan offsets 1..BUF_NUM; offset BUF_NUM revisits cur itself, which is the
  // only free slot when BUF_NUM=3 and both other buffers are excluded.
  always_comb begin
    nxt_o = cur_i;
    found = 1'b0;
    sum   = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= BUF_NUM; k++) begin
      sum = {1'b0, cur_i} + SumW'(k);
      if (sum >= SumW'(BUF_NUM)) begin
        sum = sum - SumW'(BUF_NUM);
      end
      cand = sum[BUF_IDX_W-1:0];
      if (!found && (cand != rbuf_i) && !(ready_i && (cand == latest_i))) begin
        nxt_o = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vbuf_sched.sv
// Triple-or-more frame-buffer scheduler: steers FDMA write/read buffer indices
// from write-done / read-done interrupt edges, tracking dropped and repeated frames.
module vbuf_sched
  import vbuf_pkg::*;
#(
  parameter int unsigned BUF_NUM = 3,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESET,
  input  logic                 sched_en,
  input  logic                 fdma_wirq,
  input  logic                 fdma_rirq,
  output logic [BUF_IDX_W-1:0] axi_fdma_wbuf,
  output logic [BUF_IDX_W-1:0] axi_fdma_rbuf,
  output logic                 buf_ready,
  output logic [BUF_IDX_W-1:0] latest_buf,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic [CNT_W-1:0]     rpt_cnt,
  output logic [1:0]           sched_state
);

  if ((BUF_NUM < BUF_NUM_MIN) || (BUF_NUM > BUF_NUM_MAX)) begin : g_bad_buf_num
    $error("vbuf_sched: BUF_NUM must be within 3..16");
  end

  localparam logic [BUF_IDX_W-1:0] RbufInit = BUF_IDX_W'(BUF_NUM - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  sched_state_e         state_q, state_d;
  logic                 fdma_wirq_q, fdma_rirq_q;
  logic [BUF_IDX_W-1:0] wbuf_q, wbuf_d;
  logic [BUF_IDX_W-1:0] rbuf_q, rbuf_d;
  logic [BUF_IDX_W-1:0] latest_q, latest_d;
  logic                 ready_q, ready_d;
  logic [CNT_W-1:0]     drop_q, drop_d;
  logic [CNT_W-1:0]     rpt_q, rpt_d;
  logic [BUF_IDX_W-1:0] wbuf_nxt;

  logic we, re, wr_run, rd_act, idle_entry;

  assign we         = fdma_wirq & ~fdma_wirq_q;
  assign re         = fdma_rirq & ~fdma_rirq_q;
  assign wr_run     = we && (state_q == StRun);
  assign rd_act     = re && ((state_q == StRun) || (state_q == StDrain));
  assign idle_entry = (state_q != StIdle) && (state_d == StIdle);

  // State register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; the unused encoding falls back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (sched_en) state_d = StRun;
      StRun:   if (!sched_en) state_d = StDrain;
      StDrain: if (we) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM output: expose the raw state encoding.
  always_comb begin
    sched_state = state_q;
  end

  // Write commits first, then a read may claim the frame just completed.
  always_comb begin
    rbuf_d   = rbuf_q;
    latest_d = latest_q;
    ready_d  = ready_q;
    drop_d   = drop_q;
    rpt_d    = rpt_q;
    if (wr_run) begin
      latest_d = wbuf_q;
      ready_d  = 1'b1;
      if (ready_q) drop_d = sat_inc(drop_q);
    end
    if (rd_act) begin
      if (ready_d) begin
        rbuf_d  = latest_d;
        ready_d = 1'b0;
      end else begin
        rpt_d = sat_inc(rpt_q);
      end
    end
    if (idle_entry) begin
      rbuf_d   = RbufInit;
      latest_d = '0;
      ready_d  = 1'b0;
    end
  end

  // The search sees the post-event reader and latest frame so it never collides.
  vbuf_next_sel #(
    .BUF_NUM(BUF_NUM)
  ) u_next_sel (
    .cur_i   (wbuf_q),
    .rbuf_i  (rbuf_d),
    .latest_i(latest_d),
    .ready_i (ready_d),
    .nxt_o   (wbuf_nxt)
  );

  // Writer index advances only on a committed write.
  always_comb begin
    wbuf_d = wbuf_q;
    if (wr_run) wbuf_d = wbuf_nxt;
    if (idle_entry) wbuf_d = '0;
  end

  // Edge-detect and datapath registers.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      fdma_wirq_q <= 1'b0;
      fdma_rirq_q <= 1'b0;
      wbuf_q      <= '0;
      rbuf_q      <= RbufInit;
      latest_q    <= '0;
      ready_q     <= 1'b0;
      drop_q      <= '0;
      rpt_q       <= '0;
    end else begin
      fdma_wirq_q <= fdma_wirq;
      fdma_rirq_q <= fdma_rirq;
      wbuf_q      <= wbuf_d;
      rbuf_q      <= rbuf_d;
      latest_q    <= latest_d;
      ready_q     <= ready_d;
      drop_q      <= drop_d;
      rpt_q       <= rpt_d;
    end
  end

  // Register outputs.
  always_comb begin
    axi_fdma_wbuf = wbuf_q;
    axi_fdma_rbuf = rbuf_q;
    latest_buf    = latest_q;
    buf_ready     = ready_q;
    drop_cnt      = drop_q;
    rpt_cnt       = rpt_q;
  end

endmodule

// File: tb/tb_vbuf_sched.sv
// Self-checking bench for vbuf_sched: a frame-level model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_vbuf_sched;

  localparam int N    = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, en, wirq, rirq;
  logic [3:0]    wbuf, rbuf, latest;
  logic          ready;
  logic [CW-1:0] drop, rpt;
  logic [1:0]    st;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  // Model state: buffer indices and counters as plain integers.
  int m_w, m_r, m_l, m_rdy, m_drop, m_rpt, m_st, m_wp, m_rp;
  bit m_we, m_re, m_wrote;
  int m_c;

  logic [2:0] tbl [24] = '{3'b110, 3'b100, 3'b101, 3'b100, 3'b110, 3'b111, 3'b111, 3'b100,
                           3'b110, 3'b100, 3'b110, 3'b100, 3'b101, 3'b100, 3'b111, 3'b100,
                           3'b011, 3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b110, 3'b100};

  always #5 clk = ~clk;

  vbuf_sched #(
    .BUF_NUM(N),
    .CNT_W  (CW)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .sched_en     (en),
    .fdma_wirq    (wirq),
    .fdma_rirq    (rirq),
    .axi_fdma_wbuf(wbuf),
    .axi_fdma_rbuf(rbuf),
    .buf_ready    (ready),
    .latest_buf   (latest),
    .drop_cnt     (drop),
    .rpt_cnt      (rpt),
    .sched_state  (st)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_w = 0; m_r = N - 1; m_l = 0; m_rdy = 0;
    m_drop = 0; m_rpt = 0; m_st = 0; m_wp = 0; m_rp = 0;
  endtask

  // Frame-level model: 0=idle, 1=run, 2=drain.
  always @(posedge clk) begin
    if (rst) begin
      model_reset();
    end else begin
      m_we = wirq && (m_wp == 0);
      m_re = rirq && (m_rp == 0);
      m_wp = int'(wirq);
      m_rp = int'(rirq);
      if (m_st == 0) begin
        if (en) m_st = 1;
      end else begin
        m_wrote = 1'b0;
        if (m_we && m_st == 1) begin
          if (m_rdy != 0) m_drop = sat(m_drop);
          m_l = m_w; m_rdy = 1; m_wrote = 1'b1;
        end
        if (m_re) begin
          if (m_rdy != 0) begin
            m_r = m_l; m_rdy = 0;
          end else begin
            m_rpt = sat(m_rpt);
          end
        end
        if (m_wrote) begin
          m_c = m_w;
          do m_c = (m_c + 1) % N; while (m_c == m_r || (m_rdy != 0 && m_c == m_l));
          m_w = m_c;
        end
        if (m_st == 2 && m_we) begin
          m_st = 0; m_w = 0; m_r = N - 1; m_l = 0; m_rdy = 0;
        end else if (m_st == 1 && !en) begin
          m_st = 2;
        end
      end
    end
  end

  // Compare every cycle once the DUT has been reset.
  always @(negedge clk) begin
    if (chk_on) begin
      check("wbuf", 32'(wbuf), 32'(m_w));
      check("rbuf", 32'(rbuf), 32'(m_r));
      check("latest_buf", 32'(latest), 32'(m_l));
      check("buf_ready", 32'(ready), 32'(m_rdy));
      check("drop_cnt", 32'(drop), 32'(m_drop));
      check("rpt_cnt", 32'(rpt), 32'(m_rpt));
      check("sched_state", 32'(st), 32'(m_st));
      if (st != 2'd0) check("wbuf_ne_rbuf", 32'(wbuf != rbuf), 32'd1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic w, input logic r);
    wirq = w; rirq = r;
    tick();
    wirq = 1'b0; rirq = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; wirq = 1'b0; rirq = 1'b0;
    tick(2);
    rst = 1'b0;
    chk_on = 1'b1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wirq = 1'b0; rirq = 1'b0;

    // Reset values.
    do_reset();
    check("rst_wbuf", 32'(wbuf), 32'd0);
    check("rst_rbuf", 32'(rbuf), 32'd2);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_latest", 32'(latest), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_rpt", 32'(rpt), 32'd0);
    check("rst_state", 32'(st), 32'd0);

    // Events in idle are ignored.
    pulse(1'b1, 1'b1);
    check("idle_wbuf", 32'(wbuf), 32'd0);
    check("idle_ready", 32'(ready), 32'd0);

    // Write then read.
    en = 1'b1; tick();
    check("run_state", 32'(st), 32'd1);
    pulse(1'b1, 1'b0);
    check("w1_latest", 32'(latest), 32'd0);
    check("w1_ready", 32'(ready), 32'd1);
    check("w1_wbuf", 32'(wbuf), 32'd1);
    pulse(1'b0, 1'b1);
    check("r1_rbuf", 32'(rbuf), 32'd0);
    check("r1_ready", 32'(ready), 32'd0);
    check("r1_wbuf", 32'(wbuf), 32'd1);

    // Two writes, no read: drop and wrap past the reader.
    do_reset(); tick();
    pulse(1'b1, 1'b0); pulse(1'b1, 1'b0);
    check("ww_drop", 32'(drop), 32'd1);
    check("ww_latest", 32'(latest), 32'd1);
    check("ww_wbuf", 32'(wbuf), 32'd0);

    // Read with nothing ready repeats.
    do_reset(); tick();
    pulse(1'b0, 1'b1);
    check("rep_rbuf", 32'(rbuf), 32'd2);
    check("rep_rpt", 32'(rpt), 32'd1);

    // Simultaneous write and read.
    do_reset(); tick();
    pulse(1'b1, 1'b0);
    pulse(1'b1, 1'b1);
    check("wr_drop", 32'(drop), 32'd1);
    check("wr_rbuf", 32'(rbuf), 32'd1);
    check("wr_ready", 32'(ready), 32'd0);
    check("wr_wbuf", 32'(wbuf), 32'd2);

    // Drain, read repeat in drain, write returns to idle.
    en = 1'b0; tick();
    check("drain_state", 32'(st), 32'd2);
    pulse(1'b0, 1'b1);
    check("drain_rpt", 32'(rpt), 32'd1);
    pulse(1'b1, 1'b0);
    check("d2i_state", 32'(st), 32'd0);
    check("d2i_wbuf", 32'(wbuf), 32'd0);
    check("d2i_rbuf", 32'(rbuf), 32'd2);
    check("d2i_drop", 32'(drop), 32'd1);
    do_reset();
    check("clr_drop", 32'(drop), 32'd0);
    check("clr_rpt", 32'(rpt), 32'd0);

    // Counter saturation.
    en = 1'b1; tick();
    for (int i = 0; i < CMAX + 2; i++) pulse(1'b0, 1'b1);
    check("sat_rpt", 32'(rpt), 32'(CMAX));

    // Level-table sequence with held levels, checked by the model.
    do_reset();
    for (int i = 0; i < 24; i++) begin
      en = tbl[i][2]; wirq = tbl[i][1]; rirq = tbl[i][0];
      tick();
    end
    en = 1'b1; wirq = 1'b0; rirq = 1'b0;
    tick(2);

    // Reset while the write interrupt is high; the held level is not a new edge.
    rst = 1'b1; wirq = 1'b1; tick();
    rst = 1'b0; tick(2);
    check("mid_ready", 32'(ready), 32'd0);
    wirq = 1'b0; tick();
    wirq = 1'b1; tick();
    check("post_ready", 32'(ready), 32'd1);
    check("post_latest", 32'(latest), 32'd0);
    wirq = 1'b0; tick(2);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
